pulse_tx: RTL and testbench
===========================

PULSE_TX -- requirements
Module: pulse_tx

Interface
REQ-001 SHALL provide parameter PULSE_W, default 8, meaning pulse high width in clk cycles (range 1..255).
REQ-002 SHALL provide parameter PERIOD, default 2_500_000, meaning nominal rising-edge-to-rising-edge spacing in clk cycles (24-bit).
REQ-003 SHALL provide parameter N_PULSES, default 0, meaning pulses per burst (16-bit); 0 means continuous.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin a pulse train.
REQ-007 SHALL have port stop, input, 1, single-cycle request to end the pulse train.
REQ-008 SHALL have port trim, input, 8, two's-complement period offset in cycles; present only under PERIOD_TRIM_EN.
REQ-009 SHALL have port en_out, output, 1, registered pulse output for the downstream pulse detector.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port pulse_cnt, output, 16, number of pulses emitted since the last start; wraps 0xFFFF->0.
REQ-012 SHALL have port done, output, 1, single-cycle strobe on burst completion or stop completion.

Function
REQ-013 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-014 IDLE->HIGH SHALL occur on the clock edge sampling start=1 with stop=0; en_out SHALL be 1 from that edge.
REQ-015 HIGH SHALL last exactly PULSE_W cycles, then go to LOW; LOW SHALL last P_eff-PULSE_W cycles, then go to HIGH.
REQ-016 A 24-bit phase counter SHALL reset to 0 on entry to HIGH and increment every cycle; rising edges of en_out SHALL be exactly P_eff cycles apart.
REQ-017 P_eff SHALL be latched on each HIGH entry and SHALL be clamped to a minimum of PULSE_W+1.
REQ-018 pulse_cnt SHALL increment on each HIGH entry; a start from IDLE SHALL first clear it, so the first pulse reads 1.
REQ-019 With N_PULSES>0, after the N_PULSES-th pulse's HIGH phase ends, the FSM SHALL go to IDLE and pulse done; no LOW phase follows the final pulse.
REQ-020 stop during HIGH SHALL not truncate the pulse: the pulse completes, then IDLE and done.
REQ-021 stop during LOW SHALL cause IDLE and done on the next edge.
REQ-022 start while busy SHALL be ignored; start and stop together in IDLE SHALL be ignored, with stop taking priority.
REQ-023 done SHALL be 0 except for the one cycle in which the FSM re-enters IDLE from HIGH or LOW.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously force IDLE, en_out=0, busy=0, done=0, pulse_cnt=0, and phase counter=0, including mid-pulse.
REQ-025 After rst_n is released, no pulse SHALL be emitted until a new start.

Configuration
REQ-026 With PERIOD_TRIM_EN defined, P_eff SHALL equal PERIOD + sign-extended trim, sampled at each HIGH entry.
REQ-027 Without PERIOD_TRIM_EN, the trim port SHALL be absent and P_eff SHALL equal PERIOD.

Structure
REQ-028 A shared package SHALL hold the state encoding (one-hot, 3 bits), the PERIOD/PULSE_W defaults, and the 24-bit counter width constant, for reuse by the detector side.
REQ-029 No sub-module is required; the block SHALL be a single module.

Verification (PULSE_W=4, PERIOD=20)
REQ-030 Case 1: start at cycle 0 with N_PULSES=0 -> en_out high for cycles 1-4, 21-24, and 41-44; pulse_cnt=1,2,3; busy=1.
REQ-031 Case 2: N_PULSES=3 -> three pulses; done at the edge after the third pulse falls; busy then 0; pulse_cnt holds 3.
REQ-032 Case 3: stop on the 2nd cycle of HIGH -> pulse still 4 cycles; done one cycle after fall. Stop mid-LOW -> done next cycle, no further pulse.
REQ-033 Case 4 (PERIOD_TRIM_EN): trim=-5 -> edge spacing 15; trim=+3 -> 23; trim=-20 -> clamped spacing 5.
REQ-034 Case 5: rst_n low on the 2nd HIGH cycle -> en_out 0 immediately; start and stop together in IDLE -> no pulse; start while busy -> no timing change.

Source files
------------

// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse transmitter and the matching detector side:
// one-hot state encoding, default timing, phase-counter width and the
// period clamp used when latching the effective period.
package pulse_tx_pkg;

    localparam int CNT_W       = 24;
    localparam int PULSE_W_DEF = 8;
    localparam int PERIOD_DEF  = 2_500_000;

    typedef logic [2:0]       state_t;
    typedef logic [CNT_W-1:0] phase_t;

    // One-hot states, kept as plain constants so older code can compare them directly
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_HIGH = 3'b010;
    localparam logic [2:0] ST_LOW  = 3'b100;

    // Clamp a signed period candidate into [min_p, 2^CNT_W-1]
    function automatic phase_t clamp_period(input logic signed [CNT_W+1:0] raw,
                                            input phase_t min_p);
        logic signed [CNT_W+1:0] lo;
        logic signed [CNT_W+1:0] hi;
        lo = $signed({2'b00, min_p});
        hi = $signed({2'b00, {CNT_W{1'b1}}});
        if (raw < lo) begin
            clamp_period = min_p;
        end else if (raw > hi) begin
            clamp_period = {CNT_W{1'b1}};
        end else begin
            clamp_period = raw[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pulse_tx.sv
// Periodic pulse generator with optional burst length.
// start begins a train of PULSE_W-wide pulses whose rising edges are P_eff
// cycles apart; stop ends it without truncating a pulse in progress.
// Optional build macro PERIOD_TRIM_EN adds the signed 8-bit trim port that
// offsets the period, sampled at every pulse start.
module pulse_tx
    import pulse_tx_pkg::*;
#(
    parameter int PULSE_W  = PULSE_W_DEF,
    parameter int PERIOD   = PERIOD_DEF,
    parameter int N_PULSES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
`ifdef PERIOD_TRIM_EN
    input  logic [7:0]  trim,
`endif
    output logic        en_out,
    output logic        busy,
    output logic [15:0] pulse_cnt,
    output logic        done
);

    localparam phase_t      PULSE_W_V = phase_t'(PULSE_W);
    localparam phase_t      PERIOD_V  = phase_t'(PERIOD);
    localparam phase_t      MIN_P     = phase_t'(PULSE_W + 1);
    localparam logic [15:0] N_V       = 16'(N_PULSES);
    localparam bit          BURST     = (N_PULSES != 0);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    phase_t      p_eff_q, p_eff_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        en_q;
    logic        done_q;

    logic signed [CNT_W+1:0] p_raw;
    phase_t                  p_new;
    logic                    last_pulse;

    // Candidate period for the next pulse, clamped so LOW lasts at least one cycle
    always_comb begin
`ifdef PERIOD_TRIM_EN
        p_raw = $signed({2'b00, PERIOD_V}) + $signed({{(CNT_W-6){trim[7]}}, trim});
`else
        p_raw = $signed({2'b00, PERIOD_V});
`endif
        p_new      = clamp_period(p_raw, MIN_P);
        last_pulse = BURST && (cnt_q == N_V);
    end

    // Next-state logic: IDLE -> HIGH -> LOW -> HIGH ..., with stop/burst exits
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 1'b1;
        p_eff_d     = p_eff_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    state_d     = ST_HIGH;
                    p_eff_d     = p_new;
                    cnt_d       = 16'd1;
                    stop_pend_d = 1'b0;
                end
            end
            ST_HIGH: begin
                // a stop seen mid-pulse is remembered until the pulse ends
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (phase_q == PULSE_W_V - 1'b1) begin
                    if (stop || stop_pend_q || last_pulse) begin
                        state_d     = ST_IDLE;
                        phase_d     = '0;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else if (phase_q == p_eff_q - 1'b1) begin
                    state_d = ST_HIGH;
                    phase_d = '0;
                    p_eff_d = p_new;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phase_d     = '0;
                stop_pend_d = 1'b0;
            end
        endcase
    end

    // State registers; outputs are registered from the next state so en_out is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            p_eff_q     <= MIN_P;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            p_eff_q     <= p_eff_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            en_q        <= (state_d == ST_HIGH);
            done_q      <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
        end
    end

    assign en_out    = en_q;
    assign busy      = (state_q != ST_IDLE);
    assign pulse_cnt = cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_tx.sv
// Bench for pulse_tx with PULSE_W=4, PERIOD=20: one continuous instance (a)
// and one 3-pulse burst instance (b). Define PERIOD_TRIM_EN to also cover trim.
module tb_pulse_tx;

    localparam int W  = 4;
    localparam int P  = 20;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_a = 1'b0, stop_a = 1'b0;
    logic        start_b = 1'b0, stop_b = 1'b0;
    logic [7:0]  trim = 8'd0;
    logic        en_a, busy_a, done_a, en_b, busy_b, done_b;
    logic [15:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_tx #(.PULSE_W(W), .PERIOD(P), .N_PULSES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
`ifdef PERIOD_TRIM_EN
        .trim(trim),
`endif
        .en_out(en_a), .busy(busy_a), .pulse_cnt(cnt_a), .done(done_a)
    );

    pulse_tx #(.PULSE_W(W), .PERIOD(P), .N_PULSES(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
`ifdef PERIOD_TRIM_EN
        .trim(trim),
`endif
        .en_out(en_b), .busy(busy_b), .pulse_cnt(cnt_b), .done(done_b)
    );

    // Reference model in absolute cycle time: a train is described by the cycle of
    // the current rising edge, the period in force and the pulse count.
    typedef struct packed {
        logic active;
        int   rise;
        int   cyc;
        int   p;
        int   cnt;
        logic pend;
        logic done;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic int peff(input logic [7:0] tr);
        int v;
        v = P;
`ifdef PERIOD_TRIM_EN
        v = v + int'($signed(tr));
`endif
        if (v < W + 1) v = W + 1;
        return v;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic st, input logic sp,
                                  input logic [7:0] tr, input int np);
        mdl_t n;
        int   pos;
        n      = m;
        n.cyc  = m.cyc + 1;
        n.done = 1'b0;
        if (!m.active) begin
            if (st && !sp) begin
                n.active = 1'b1;
                n.cnt    = 1;
                n.rise   = n.cyc;
                n.p      = peff(tr);
                n.pend   = 1'b0;
            end
        end else begin
            pos = m.cyc - m.rise;
            if (pos < W) begin
                if (sp) n.pend = 1'b1;
                if (pos == W - 1 && (n.pend || (np != 0 && m.cnt == np))) begin
                    n.active = 1'b0;
                    n.done   = 1'b1;
                end
            end else if (sp) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end else if (pos == m.p - 1) begin
                n.rise = n.cyc;
                n.cnt  = (m.cnt + 1) % 65536;
                n.p    = peff(tr);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, start_a, stop_a, trim, 0);
            mb <= step(mb, start_b, stop_b, trim, NB);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("a_en",   {31'd0, en_a},   {31'd0, ma.active && (ma.cyc - ma.rise) < W});
        chk("a_busy", {31'd0, busy_a}, {31'd0, ma.active});
        chk("a_done", {31'd0, done_a}, {31'd0, ma.done});
        chk("a_cnt",  {16'd0, cnt_a},  ma.cnt);
        chk("b_en",   {31'd0, en_b},   {31'd0, mb.active && (mb.cyc - mb.rise) < W});
        chk("b_busy", {31'd0, busy_b}, {31'd0, mb.active});
        chk("b_done", {31'd0, done_b}, {31'd0, mb.done});
        chk("b_cnt",  {16'd0, cnt_b},  mb.cnt);
    endtask

    // One clock cycle: inputs set by the caller are sampled at the edge,
    // outputs are compared at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        bit which_b;
        int cyc;
        bit en;
        int cnt;
        bit busy;
        bit done;
    } vec_t;

    vec_t tab[$];

    task automatic add_vec(input bit b, input int c, input bit e, input int n,
                           input bit bz, input bit d);
        vec_t v;
        v.which_b = b; v.cyc = c; v.en = e; v.cnt = n; v.busy = bz; v.done = d;
        tab.push_back(v);
    endtask

`ifdef PERIOD_TRIM_EN
    task automatic measure(input int tr, input int exp_sp);
        int   first, second;
        logic prev;
        first = -1; second = -1; prev = 1'b0;
        trim = 8'(tr);
        start_a = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (k == 1) start_a = 1'b0;
            if (en_a && !prev) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            prev = en_a;
        end
        chk($sformatf("trim%0d_spacing", tr), (second < 0) ? 32'hFFFF_FFFF : 32'(second - first), 32'(exp_sp));
        $display("trim %0d: spacing %0d", tr, second - first);
        stop_a = 1'b1; cyc(); stop_a = 1'b0;
        repeat (6) cyc();
        trim = 8'd0;
    endtask
`endif

    initial begin
        // Case 1 (a, continuous) and case 2 (b, burst of 3): cycle, en, cnt, busy, done
        add_vec(0, 1, 1, 1, 1, 0);  add_vec(0, 4, 1, 1, 1, 0);
        add_vec(0, 5, 0, 1, 1, 0);  add_vec(0, 20, 0, 1, 1, 0);
        add_vec(0, 21, 1, 2, 1, 0); add_vec(0, 24, 1, 2, 1, 0);
        add_vec(0, 25, 0, 2, 1, 0); add_vec(0, 40, 0, 2, 1, 0);
        add_vec(0, 41, 1, 3, 1, 0); add_vec(0, 44, 1, 3, 1, 0);
        add_vec(0, 45, 0, 3, 1, 0);
        add_vec(1, 41, 1, 3, 1, 0); add_vec(1, 44, 1, 3, 1, 0);
        add_vec(1, 45, 0, 3, 0, 1); add_vec(1, 46, 0, 3, 0, 0);
        add_vec(1, 50, 0, 3, 0, 0);

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_en", {31'd0, en_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
        chk("rst_done", {31'd0, done_b}, 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        $display("reset state checked");

        // Table-driven cases 1 and 2
        start_a = 1'b1; start_b = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            if (k == 1) begin start_a = 1'b0; start_b = 1'b0; end
            for (int i = 0; i < tab.size(); i++) begin
                if (tab[i].cyc == k) begin
                    if (tab[i].which_b) begin
                        chk($sformatf("b_c%0d_en", k),   {31'd0, en_b},   {31'd0, tab[i].en});
                        chk($sformatf("b_c%0d_cnt", k),  {16'd0, cnt_b},  tab[i].cnt);
                        chk($sformatf("b_c%0d_busy", k), {31'd0, busy_b}, {31'd0, tab[i].busy});
                        chk($sformatf("b_c%0d_done", k), {31'd0, done_b}, {31'd0, tab[i].done});
                    end else begin
                        chk($sformatf("a_c%0d_en", k),   {31'd0, en_a},   {31'd0, tab[i].en});
                        chk($sformatf("a_c%0d_cnt", k),  {16'd0, cnt_a},  tab[i].cnt);
                        chk($sformatf("a_c%0d_busy", k), {31'd0, busy_a}, {31'd0, tab[i].busy});
                        chk($sformatf("a_c%0d_done", k), {31'd0, done_a}, {31'd0, tab[i].done});
                    end
                end
            end
        end
        stop_a = 1'b1; cyc(); stop_a = 1'b0;
        repeat (4) cyc();
        $display("continuous and burst tables applied");

        // Stop on the 2nd HIGH cycle: pulse completes, done right after the fall
        start_a = 1'b1; cyc(); start_a = 1'b0;     // cycle 1
        cyc();                                     // cycle 2
        stop_a = 1'b1; cyc(); stop_a = 1'b0;       // cycle 3
        cyc();                                     // cycle 4
        chk("stoph_c4_en", {31'd0, en_a}, 32'd1);
        cyc();                                     // cycle 5
        chk("stoph_c5_en", {31'd0, en_a}, 32'd0);
        chk("stoph_c5_done", {31'd0, done_a}, 32'd1);
        chk("stoph_c5_busy", {31'd0, busy_a}, 32'd0);
        cyc();
        chk("stoph_c6_done", {31'd0, done_a}, 32'd0);
        $display("stop during HIGH checked");

        // Stop mid-LOW: done on the next cycle, no later pulse
        start_a = 1'b1; cyc(); start_a = 1'b0;
        for (int k = 2; k <= 10; k++) cyc();
        stop_a = 1'b1; cyc(); stop_a = 1'b0;       // cycle 11
        chk("stopl_c11_done", {31'd0, done_a}, 32'd1);
        chk("stopl_c11_busy", {31'd0, busy_a}, 32'd0);
        for (int k = 12; k <= 22; k++) cyc();
        chk("stopl_c22_en", {31'd0, en_a}, 32'd0);
        $display("stop during LOW checked");

        // Asynchronous reset on the 2nd HIGH cycle
        start_a = 1'b1; cyc(); start_a = 1'b0;
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_en", {31'd0, en_a}, 32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_cnt", {16'd0, cnt_a}, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (25) cyc();
        chk("arst_quiet_busy", {31'd0, busy_a}, 32'd0);
        $display("mid-pulse reset checked");

        // start and stop together in IDLE: ignored
        start_a = 1'b1; stop_a = 1'b1; cyc(); start_a = 1'b0; stop_a = 1'b0;
        chk("ss_en", {31'd0, en_a}, 32'd0);
        chk("ss_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) cyc();
        $display("simultaneous start/stop checked");

        // start while busy: timing unchanged
        start_a = 1'b1; cyc(); start_a = 1'b0;
        for (int k = 2; k <= 21; k++) begin
            if (k == 3 || k == 10) start_a = 1'b1;
            cyc();
            start_a = 1'b0;
            if (k == 20) chk("sb_c20_en", {31'd0, en_a}, 32'd0);
            if (k == 21) begin
                chk("sb_c21_en", {31'd0, en_a}, 32'd1);
                chk("sb_c21_cnt", {16'd0, cnt_a}, 32'd2);
            end
        end
        stop_a = 1'b1; cyc(); stop_a = 1'b0;
        repeat (6) cyc();
        $display("start while busy checked");

`ifdef PERIOD_TRIM_EN
        measure(-5, 15);
        measure(3, 23);
        measure(-20, 5);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            start_a = ($urandom_range(0, 19) == 0);
            stop_a  = ($urandom_range(0, 59) == 0);
            start_b = ($urandom_range(0, 19) == 0);
            stop_b  = ($urandom_range(0, 59) == 0);
            trim    = 8'($urandom_range(0, 255));
            cyc();
        end
        start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
        $display("random traffic applied");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
